log2_iter: RTL and testbench
============================

// Module: log2_iter
// PURPOSE
//  Iterative signed fixed-point base-2 logarithm unit with ready/valid handshakes on input and output.
//  Parametrised in input format (M integer / N fraction bits), output fraction precision F and rounding mode.
//  Flags non-positive inputs instead of producing garbage.
//  Sits between a ready/valid producer and consumer; processes one operand at a time.
// PARAMETERS
//  M      2  input integer bits (excl. sign); input W = M+N+1 bits, signed, value = x/2^N
//  N      5  input fraction bits
//  F      5  output fraction bits
//  ROUND  0  0 = truncate result, 1 = round-to-nearest (one extra iteration)
//  derived: I = $clog2(M+N+1)+1 output integer bits (signed); OW = I+F; MW = M+N mantissa bits (Q1.(MW-1))
// PORTS
//  clk_i      in   1   clock, rising edge
//  rstn_i     in   1   synchronous reset, active-high (asserted = 1)
//  valid_i    in   1   upstream operand valid
//  ready_o    out  1   unit can accept operand
//  number     in   W   signed operand, Q(M).(N)
//  valid_o    out  1   result valid
//  ready_i    in   1   downstream accepts result
//  logNumber  out  OW  signed result log2(number), Q(I-1).(F), two's complement
//  err_o      out  1   operand was <= 0; qualified by valid_o
// BEHAVIOUR
//  Reset: state IDLE, valid_o=0, ready_o=1, logNumber=0, err_o=0, iteration counter=0; applies from any state (incl. mid-ITER) on the next edge.
//  Accept on valid_i & ready_o; ready_o = (state==IDLE) only; operand registered at accept.
//  FSM:
//   IDLE -> NORM on accept with number>0.
//   IDLE -> DONE on accept with number<=0; err_o=1, logNumber=0.
//   NORM (1 cycle): p = index of leading one of number[W-2:0];
//    integer part = p-N (signed, I bits); mantissa y = number normalised so bit p maps to the MW-1 integer bit.
//   ITER (F+ROUND cycles): y2 = y*y (2*MW bits, Q2.(2MW-2)); truncate to Q2.(MW-1).
//    If y2>=2: bit=1, y = y2>>1 truncated to MW bits. Else bit=0, y = y2 truncated.
//    Bits shift into the fraction register MSB-first.
//   DONE: valid_o=1; logNumber, err_o held stable while ready_i=0; DONE -> IDLE when ready_i=1.
//  ROUND=1: the extra (F+1)th bit is added at the LSB of the F-bit fraction; carry propagates into the integer part.
//   No overflow is possible: max integer part M-1, +1 fits in I bits.
//  Latency accept->valid_o: positive operand F+ROUND+2 cycles; error path 1 cycle.
//  Minimum initiation interval: latency+1 (ready_o rises the cycle after the output handshake).
//  valid_i while busy is ignored (no accept). number need not stay stable after accept.
//  Exact powers of two yield fraction 0 in both modes.
//  Minimum input (1 LSB) gives integer part -N.
// TESTING  (M=2,N=5,F=5 unless noted: W=8, OW=9)
//  1. number=8'h20 (1.0) -> logNumber=9'h000, err_o=0, valid_o exactly 7 cycles after accept.
//  2. number=8'h40 (2.0) -> 9'h020. number=8'h01 (1/32) -> 9'h160 (-5.0).
//     number=8'h7F -> integer part 1, err_o=0.
//  3. number=8'h60 (3.0): ROUND=0 -> 9'h032. ROUND=1 -> 9'h033, valid_o 8 cycles after accept.
//  4. number=8'h00, then 8'h80 -> each valid_o 1 cycle after accept with err_o=1, logNumber=0.
//  5. Hold ready_i=0 for 4 cycles in DONE -> valid_o, logNumber, err_o stable; ready_o=0.
//     valid_i pulses meanwhile are not accepted; ready_i=1 -> IDLE, next operand accepted.
//  6. Assert rstn_i during ITER cycle 2 -> next edge valid_o=0, ready_o=1;
//     following operand 8'h40 gives 9'h020. Random sweep vs real log2 model: error <1 LSB (trunc) / <=0.5 LSB + 1 (round).

Source files
------------

// File: rtl/log2_iter_if.sv
// Ready/valid operand and result channels of the iterative log2 unit.
interface log2_iter_if #(
    parameter int unsigned W  = 8,
    parameter int unsigned OW = 9
);
    logic          valid_i;
    logic          ready_o;
    logic [W-1:0]  number;
    logic          valid_o;
    logic          ready_i;
    logic [OW-1:0] logNumber;
    logic          err_o;

    modport slave (
        input  valid_i, number, ready_i,
        output ready_o, valid_o, logNumber, err_o
    );

    modport master (
        output valid_i, number, ready_i,
        input  ready_o, valid_o, logNumber, err_o
    );
endinterface

// File: rtl/log2_iter.sv
// Iterative signed fixed-point log2: normalise to a Q1 mantissa, then produce one
// fraction bit per cycle by repeated squaring. Non-positive operands raise err_o.
module log2_iter #(
    parameter int unsigned M     = 2,
    parameter int unsigned N     = 5,
    parameter int unsigned F     = 5,
    parameter int unsigned ROUND = 0
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    log2_iter_if.slave  bus
);
    localparam int unsigned W  = M + N + 1;
    localparam int unsigned MW = M + N;
    localparam int unsigned I  = $clog2(M + N + 1) + 1;
    localparam int unsigned OW = I + F;
    localparam int unsigned FW = F + ROUND;
    localparam int unsigned CW = $clog2(FW + 1);
    localparam int unsigned PW = (MW > 1) ? $clog2(MW) : 1;

    typedef enum logic [1:0] {IDLE, NORM, ITER, DONE} state_t;

    state_t        state_q, state_d;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [OW-1:0] res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [MW-1:0] opnd_q, opnd_d;
    logic [MW-1:0] y_q, y_d;
    logic [FW-1:0] frac_q, frac_d;
    logic [I-1:0]  int_q, int_d;

    logic [PW-1:0]   lead;
    logic [MW-1:0]   y_norm;
    logic [I-1:0]    int_norm;
    logic [2*MW-1:0] sq;
    logic [MW:0]     y2t;
    logic            sq_bit;
    logic [MW-1:0]   y_next;
    logic [FW-1:0]   frac_next;
    logic            rnd_bit;
    logic [OW-1:0]   res_next;
    logic            opnd_pos;

    // Leading-one position of the registered magnitude (highest set bit wins).
    always_comb begin
        lead = '0;
        for (int i = 0; i < int'(MW); i++) begin
            if (opnd_q[i]) lead = PW'(i);
        end
    end

    // Normalisation, squaring step and result assembly.
    always_comb begin
        y_norm    = opnd_q << (PW'(MW - 1) - lead);
        int_norm  = I'(lead) - I'(N);
        sq        = (2*MW)'(y_q) * (2*MW)'(y_q);
        y2t       = (MW+1)'(sq >> (MW - 1));
        sq_bit    = y2t[MW];
        y_next    = sq_bit ? y2t[MW:1] : y2t[MW-1:0];
        frac_next = FW'({frac_q, sq_bit});
        rnd_bit   = (ROUND != 0) ? frac_next[0] : 1'b0;
        res_next  = {int_q, frac_next[FW-1 -: F]} + OW'(rnd_bit);
        opnd_pos  = ~bus.number[W-1] & (|bus.number[W-2:0]);
    end

    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            opnd_q  <= '0;
            y_q     <= '0;
            frac_q  <= '0;
            int_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            y_q     <= y_d;
            frac_q  <= frac_d;
            int_q   <= int_d;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        valid_d = valid_q;
        err_d   = err_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        y_d     = y_q;
        frac_d  = frac_q;
        int_d   = int_q;
        unique case (state_q)
            IDLE: begin
                if (bus.valid_i && ready_q) begin
                    opnd_d  = bus.number[W-2:0];
                    ready_d = 1'b0;
                    if (opnd_pos) begin
                        state_d = NORM;
                    end else begin
                        state_d = DONE;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                        res_d   = '0;
                    end
                end
            end
            NORM: begin
                y_d     = y_norm;
                int_d   = int_norm;
                cnt_d   = '0;
                frac_d  = '0;
                state_d = ITER;
            end
            ITER: begin
                y_d    = y_next;
                frac_d = frac_next;
                cnt_d  = CW'(cnt_q + 1'b1);
                if (cnt_q == CW'(FW - 1)) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                    res_d   = res_next;
                end
            end
            DONE: begin
                if (bus.ready_i) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready_o   = ready_q;
    assign bus.valid_o   = valid_q;
    assign bus.logNumber = res_q;
    assign bus.err_o     = err_q;
endmodule

// File: tb/tb_log2_iter.sv
// Bench for log2_iter: truncating (dut 0) and rounding (dut 1) instances against
// a squaring-rule model and an ideal real-valued log2.
module tb_log2_iter;
    localparam int N = 5;
    localparam int F = 5;

    logic       clk_i;
    logic       rstn_i;
    logic       vi  [2];
    logic [7:0] num [2];
    logic       ri  [2];
    logic       ro  [2];
    logic       vo  [2];
    logic       eo  [2];
    logic [8:0] ln  [2];

    int vectors = 0;
    int errors  = 0;

    log2_iter_if #(.W(8), .OW(9)) ifc0 ();
    log2_iter_if #(.W(8), .OW(9)) ifc1 ();

    log2_iter #(.M(2), .N(5), .F(5), .ROUND(0)) u_dut0 (.clk_i(clk_i), .rstn_i(rstn_i), .bus(ifc0));
    log2_iter #(.M(2), .N(5), .F(5), .ROUND(1)) u_dut1 (.clk_i(clk_i), .rstn_i(rstn_i), .bus(ifc1));

    assign ifc0.valid_i = vi[0];
    assign ifc0.number  = num[0];
    assign ifc0.ready_i = ri[0];
    assign ifc1.valid_i = vi[1];
    assign ifc1.number  = num[1];
    assign ifc1.ready_i = ri[1];
    assign ro[0] = ifc0.ready_o;
    assign vo[0] = ifc0.valid_o;
    assign eo[0] = ifc0.err_o;
    assign ln[0] = ifc0.logNumber;
    assign ro[1] = ifc1.ready_o;
    assign vo[1] = ifc1.valid_o;
    assign eo[1] = ifc1.err_o;
    assign ln[1] = ifc1.logNumber;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected result from the squaring rules, using plain integer arithmetic.
    task automatic model(input int x, input int rnd, output logic [8:0] res,
                         output logic err, output int lat);
        int p, y, frac, value;
        if (x <= 0) begin
            res = '0; err = 1'b1; lat = 1;
        end else begin
            p = 0;
            while ((1 << (p + 1)) <= x) p++;
            y = x * (1 << (6 - p));
            frac = 0;
            for (int k = 0; k < F + rnd; k++) begin
                y = (y * y) / 64;
                if (y >= 128) begin
                    y = y / 2;
                    frac = frac * 2 + 1;
                end else begin
                    frac = frac * 2;
                end
            end
            value = (p - N) * 32 + ((rnd != 0) ? (frac + 1) / 2 : frac);
            res = 9'(value);
            err = 1'b0;
            lat = F + rnd + 2;
        end
    endtask

    // One transaction on dut d; hold = cycles of ready_i=0 after valid_o rises.
    task automatic run_op(input int d, input logic [7:0] x, input int hold, input int spec_res);
        logic [8:0] eres, hres;
        logic       eerr, herr;
        int         elat, lat, gi;
        real        tv, gv, diff;
        model(int'($signed(x)), d, eres, eerr, elat);
        check("ready_before_accept", 32'(ro[d]), 32'd1);
        vi[d] = 1'b1;
        num[d] = x;
        @(posedge clk_i); #1;
        vi[d] = 1'b0;
        num[d] = 8'($urandom);
        lat = 1;
        while (vo[d] !== 1'b1 && lat < 40) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(elat));
        check("result", 32'(ln[d]), 32'(eres));
        check("err", 32'(eo[d]), 32'(eerr));
        if (spec_res >= 0) check("spec_value", 32'(ln[d]), 32'(spec_res));
        if (!eerr) begin
            tv = $ln(real'(int'($signed(x))) / 32.0) / $ln(2.0);
            gi = int'($signed(ln[d]));
            gv = real'(gi) / 32.0;
            diff = (tv > gv) ? tv - gv : gv - tv;
            check("ideal_bound", 32'(diff < 2.0 / 32.0), 32'd1);
        end
        hres = ln[d];
        herr = eo[d];
        for (int h = 0; h < hold; h++) begin
            vi[d] = 1'b1;
            num[d] = 8'h01;
            @(posedge clk_i); #1;
            vi[d] = 1'b0;
            check("hold_valid", 32'(vo[d]), 32'd1);
            check("hold_result", 32'(ln[d]), 32'(hres));
            check("hold_err", 32'(eo[d]), 32'(herr));
            check("hold_ready", 32'(ro[d]), 32'd0);
        end
        ri[d] = 1'b1;
        @(posedge clk_i); #1;
        ri[d] = 1'b0;
        check("valid_drop", 32'(vo[d]), 32'd0);
        check("ready_back", 32'(ro[d]), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            vi[d] = 1'b0; num[d] = '0; ri[d] = 1'b0;
        end
        rstn_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rstn_i = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", 32'(ro[d]), 32'd1);
            check("rst_valid", 32'(vo[d]), 32'd0);
            check("rst_result", 32'(ln[d]), 32'd0);
            check("rst_err", 32'(eo[d]), 32'd0);
        end

        // Directed values with results known independently of the model.
        run_op(0, 8'h20, 0, 9'h000);
        run_op(0, 8'h40, 0, 9'h020);
        run_op(0, 8'h01, 0, 9'h160);
        run_op(0, 8'h7F, 0, -1);
        check("int_part_7f", 32'(ln[0][8:5]), 32'd1);
        run_op(0, 8'h60, 0, 9'h032);
        run_op(1, 8'h60, 0, 9'h033);
        run_op(1, 8'h20, 0, 9'h000);
        run_op(1, 8'h40, 0, 9'h020);
        run_op(0, 8'h00, 0, 9'h000);
        run_op(0, 8'h80, 0, 9'h000);
        run_op(1, 8'h00, 0, 9'h000);

        // Backpressure with ignored valid_i pulses, then a normal operand.
        run_op(0, 8'h60, 4, 9'h032);
        run_op(0, 8'h40, 0, 9'h020);

        // Reset in the second iteration cycle.
        vi[0] = 1'b1;
        num[0] = 8'h60;
        @(posedge clk_i); #1;
        vi[0] = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        @(posedge clk_i); #1;
        rstn_i = 1'b0;
        check("midrst_valid", 32'(vo[0]), 32'd0);
        check("midrst_ready", 32'(ro[0]), 32'd1);
        run_op(0, 8'h40, 0, 9'h020);

        // Random sweep over both rounding modes.
        for (int t = 0; t < 60; t++) begin
            logic [7:0] x;
            x = 8'($urandom);
            if ($urandom_range(0, 3) != 0) x[7] = 1'b0;
            run_op(int'($urandom_range(0, 1)), x, int'($urandom_range(0, 2)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
